// File: rtl/sap_fp_pkg.sv
// Shared types and helpers for the SAP front-panel memory loader.
// Event codes double as priorities: a higher code wins when several arrive together.
package sap_fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EDIT  = 3'd3,
        ST_WRITE = 3'd4
    } fp_state_t;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_KEY   = 3'd1,
        EV_MOVE  = 3'd2,
        EV_GOTO  = 3'd3,
        EV_WRITE = 3'd4
    } fp_event_t;

    // next_p and prev_p together cancel out and are treated as absent.
    function automatic fp_event_t fp_pick_event(input logic write_p, input logic goto_p,
                                                input logic next_p, input logic prev_p,
                                                input logic key_valid);
        fp_event_t ev;
        ev = EV_NONE;
        if (write_p)              ev = EV_WRITE;
        else if (goto_p)          ev = EV_GOTO;
        else if (next_p ^ prev_p) ev = EV_MOVE;
        else if (key_valid)       ev = EV_KEY;
        return ev;
    endfunction

    function automatic bit fp_params_ok(input int addr_w, input int data_w, input int rd_lat);
        return (addr_w >= 1) && (data_w >= 4) && ((data_w % 4) == 0) && (rd_lat >= 1);
    endfunction

endpackage

// File: rtl/fp_nibble_shift.sv
// Edit register for the front panel: parallel load from memory read data,
// or shift left by one nibble inserting the new keypad digit at the bottom.
module fp_nibble_shift #(
    parameter int DATA_W = 8
) (
    input  logic              CLOCK_100MHZ,
    input  logic              CLR,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic [3:0]        nibble,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] data_q, data_d, shifted;

    if (DATA_W == 4) begin : g_narrow
        assign shifted = nibble;
    end else begin : g_wide
        assign shifted = {data_q[DATA_W-5:0], nibble};
    end

    always_comb begin
        data_d = data_q;
        if (load)       data_d = load_data;
        else if (shift) data_d = shifted;
    end

    always_ff @(posedge CLOCK_100MHZ or posedge CLR) begin
        if (CLR) data_q <= '0;
        else     data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/fp_loader.sv
// Front-panel loader: turns debounced panel events into a read-modify-write
// session on program RAM through the memory's front-panel port.
//
// state    | meaning
// ST_IDLE  | program mode off; only goto_p acts (loads address, no fetch)
// ST_FETCH | one-cycle read strobe at mem_adr
// ST_WAIT  | down-count RD_LAT cycles, capture mem_rdata on terminal count
// ST_EDIT  | accept one panel event per cycle
// ST_WRITE | one-cycle write strobe of edit_data at mem_adr
module fp_loader
    import sap_fp_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int AUTO_INC = 1
) (
    input  logic              CLOCK_100MHZ,
    input  logic              CLR,
    input  logic              prog,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              next_p,
    input  logic              prev_p,
    input  logic              goto_p,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic              write_p,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] edit_data,
    output logic              dirty,
    output logic              busy
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    if (!fp_params_ok(ADDR_W, DATA_W, RD_LAT)) begin : g_param_check
        $error("fp_loader: illegal parameter set");
    end

    fp_state_t         state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dirty_q, dirty_d;
    logic              re_q, re_d, we_q, we_d, busy_q, busy_d;
    logic              sh_load, sh_shift;
    fp_event_t         evt;

    assign evt = fp_pick_event(write_p, goto_p, next_p, prev_p, key_valid);

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        dirty_d  = dirty_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (goto_p) adr_d = base_adr;
                if (prog)   state_d = ST_FETCH;
            end
            ST_FETCH: begin
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    sh_load = 1'b1;
                    dirty_d = 1'b0;
                    state_d = ST_EDIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EDIT: begin
                case (evt)
                    EV_WRITE: state_d = ST_WRITE;
                    EV_GOTO: begin
                        adr_d   = base_adr;
                        dirty_d = 1'b0;
                        state_d = ST_FETCH;
                    end
                    EV_MOVE: begin
                        adr_d   = next_p ? adr_q + ADDR_W'(1) : adr_q - ADDR_W'(1);
                        dirty_d = 1'b0;
                        state_d = ST_FETCH;
                    end
                    EV_KEY: begin
                        sh_shift = 1'b1;
                        dirty_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_WRITE: begin
                dirty_d = 1'b0;
                if (AUTO_INC != 0) begin
                    adr_d   = adr_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EDIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Leaving program mode abandons the session but keeps address and data for display.
        if (!prog && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            adr_d    = adr_q;
            dirty_d  = 1'b0;
            sh_load  = 1'b0;
            sh_shift = 1'b0;
        end
    end

    assign re_d   = (state_d == ST_FETCH);
    assign we_d   = (state_d == ST_WRITE);
    assign busy_d = re_d | we_d | (state_d == ST_WAIT);

    always_ff @(posedge CLOCK_100MHZ or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            dirty_q <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            re_q    <= re_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    fp_nibble_shift #(.DATA_W(DATA_W)) u_shift (
        .CLOCK_100MHZ (CLOCK_100MHZ),
        .CLR          (CLR),
        .load         (sh_load),
        .load_data    (mem_rdata),
        .shift        (sh_shift),
        .nibble       (key_code),
        .data         (edit_data)
    );

    assign mem_adr   = adr_q;
    assign mem_wdata = edit_data;
    assign mem_re    = re_q & prog;
    assign mem_we    = we_q & prog;
    assign dirty     = dirty_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp_loader.sv
// Bench for fp_loader: three instances (default, no auto-increment, 16-bit/RD_LAT=3)
// each with its own behavioural RAM; expectations come from a panel-level model.
module tb_fp_loader;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic       key_valid = 1'b0, next_p = 1'b0, prev_p = 1'b0, goto_p = 1'b0, write_p = 1'b0;
    logic [3:0] key_code = 4'd0, base_adr = 4'd0;
    logic       prog_a = 1'b0, prog_b = 1'b0, prog_c = 1'b0;

    logic [3:0]  adr_a, adr_b, adr_c;
    logic        re_a, re_b, re_c, we_a, we_b, we_c;
    logic        dirty_a, dirty_b, dirty_c, busy_a, busy_b, busy_c;
    logic [7:0]  rdata_a, rdata_b, wdata_a, wdata_b, edit_a, edit_b;
    logic [15:0] rdata_c, wdata_c, edit_c;

    logic [7:0]  mem_a [16];
    logic [7:0]  mem_b [16];
    logic [15:0] mem_c [16];
    logic [15:0] pipe_c [3];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_adr = 4'd0;
    logic [7:0]  pre_a = 8'd0, pre_b = 8'd0;
    logic [15:0] pre_c = 16'd0;

    logic [7:0]  ref_a [16];
    logic [7:0]  ref_b [16];
    logic [15:0] ref_c [16];
    logic [3:0]  m_adr;
    logic [7:0]  m_edit;
    logic        m_dirty;

    int checks = 0;
    int errors = 0;

    fp_loader u_a (
        .CLOCK_100MHZ(clk), .CLR(clr), .prog(prog_a), .key_valid(key_valid), .key_code(key_code),
        .next_p(next_p), .prev_p(prev_p), .goto_p(goto_p), .base_adr(base_adr), .write_p(write_p),
        .mem_rdata(rdata_a), .mem_adr(adr_a), .mem_re(re_a), .mem_we(we_a), .mem_wdata(wdata_a),
        .edit_data(edit_a), .dirty(dirty_a), .busy(busy_a));

    fp_loader #(.AUTO_INC(0)) u_b (
        .CLOCK_100MHZ(clk), .CLR(clr), .prog(prog_b), .key_valid(key_valid), .key_code(key_code),
        .next_p(next_p), .prev_p(prev_p), .goto_p(goto_p), .base_adr(base_adr), .write_p(write_p),
        .mem_rdata(rdata_b), .mem_adr(adr_b), .mem_re(re_b), .mem_we(we_b), .mem_wdata(wdata_b),
        .edit_data(edit_b), .dirty(dirty_b), .busy(busy_b));

    fp_loader #(.DATA_W(16), .RD_LAT(3)) u_c (
        .CLOCK_100MHZ(clk), .CLR(clr), .prog(prog_c), .key_valid(key_valid), .key_code(key_code),
        .next_p(next_p), .prev_p(prev_p), .goto_p(goto_p), .base_adr(base_adr), .write_p(write_p),
        .mem_rdata(rdata_c), .mem_adr(adr_c), .mem_re(re_c), .mem_we(we_c), .mem_wdata(wdata_c),
        .edit_data(edit_c), .dirty(dirty_c), .busy(busy_c));

    // Behavioural RAMs; reads return zero unless strobed, so a mistimed capture shows up.
    always @(posedge clk) begin
        if (pre_we) begin
            mem_a[pre_adr] <= pre_a;
            mem_b[pre_adr] <= pre_b;
            mem_c[pre_adr] <= pre_c;
        end else begin
            if (we_a) mem_a[adr_a] <= wdata_a;
            if (we_b) mem_b[adr_b] <= wdata_b;
            if (we_c) mem_c[adr_c] <= wdata_c;
        end
        rdata_a   <= re_a ? mem_a[adr_a] : 8'h00;
        rdata_b   <= re_b ? mem_b[adr_b] : 8'h00;
        pipe_c[0] <= re_c ? mem_c[adr_c] : 16'h0000;
        pipe_c[1] <= pipe_c[0];
        pipe_c[2] <= pipe_c[1];
    end
    assign rdata_c = pipe_c[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        key_valid = 1'b0; next_p = 1'b0; prev_p = 1'b0; goto_p = 1'b0; write_p = 1'b0;
    endtask

    task automatic wait_ready(input int which, input string tag);
        logic b;
        for (int i = 0; i < 12; i++) begin
            b = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
            checks++;
            if (!b) return;
            checks--;
            tick();
        end
        checks++; errors++;
        $display("FAIL %s_timeout: busy=1 after 12 cycles, expected 0", tag);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pre_adr = 4'(i);
            pre_a = (i == 3) ? 8'hA5 : 8'($urandom);
            pre_b = 8'($urandom);
            pre_c = (i == 2) ? 16'hBEEF : 16'($urandom);
            ref_a[i] = pre_a; ref_b[i] = pre_b; ref_c[i] = pre_c;
            pre_we = 1'b1;
            tick();
        end
        pre_we = 1'b0;
        checks++; if (adr_a !== 4'd0) begin errors++; $display("FAIL rst_adr: got %0h expected 0", adr_a); end
        checks++; if (edit_a !== 8'd0) begin errors++; $display("FAIL rst_edit: got %0h expected 0", edit_a); end
        checks++; if (dirty_a !== 1'b0) begin errors++; $display("FAIL rst_dirty: got %0b expected 0", dirty_a); end
        checks++; if (re_a !== 1'b0 || we_a !== 1'b0) begin errors++; $display("FAIL rst_strobes: got re=%0b we=%0b expected 0 0", re_a, we_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy_a); end
        checks++; if (edit_c !== 16'd0) begin errors++; $display("FAIL rst_edit_c: got %0h expected 0", edit_c); end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        goto_p = 1'b1; base_adr = 4'd3;
        tick(); clear_ev();
        checks++; if (adr_a !== 4'd3) begin errors++; $display("FAIL idle_goto_adr: got %0h expected 3", adr_a); end
        checks++; if (re_a !== 1'b0) begin errors++; $display("FAIL idle_goto_nofetch: got re=%0b expected 0", re_a); end
        prog_a = 1'b1;
        tick();
        checks++; if (re_a !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL fetch_re: got re=%0b busy=%0b expected 1 1", re_a, busy_a); end
        tick();
        checks++; if (re_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL wait_state: got re=%0b busy=%0b expected 0 1", re_a, busy_a); end
        tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL edit_entry_busy: got %0b expected 0", busy_a); end
        checks++; if (edit_a !== 8'hA5) begin errors++; $display("FAIL edit_entry_data: got %0h expected a5", edit_a); end
        checks++; if (dirty_a !== 1'b0) begin errors++; $display("FAIL edit_entry_dirty: got %0b expected 0", dirty_a); end
    endtask

    task automatic test_edit_write();
        key_valid = 1'b1; key_code = 4'h1; tick(); clear_ev();
        checks++; if (edit_a !== 8'h51) begin errors++; $display("FAIL key1: got %0h expected 51", edit_a); end
        key_valid = 1'b1; key_code = 4'h2; tick(); clear_ev();
        checks++; if (edit_a !== 8'h12 || dirty_a !== 1'b1) begin errors++; $display("FAIL key2: got %0h dirty=%0b expected 12 dirty=1", edit_a, dirty_a); end
        write_p = 1'b1; tick(); clear_ev();
        checks++; if (we_a !== 1'b1 || adr_a !== 4'd3 || wdata_a !== 8'h12) begin
            errors++; $display("FAIL write_strobe: got we=%0b adr=%0h data=%0h expected 1 3 12", we_a, adr_a, wdata_a); end
        ref_a[3] = 8'h12;
        tick();
        checks++; if (we_a !== 1'b0 || re_a !== 1'b1 || adr_a !== 4'd4 || dirty_a !== 1'b0) begin
            errors++; $display("FAIL autoinc_refetch: got we=%0b re=%0b adr=%0h dirty=%0b expected 0 1 4 0", we_a, re_a, adr_a, dirty_a); end
        wait_ready(0, "autoinc");
        checks++; if (edit_a !== ref_a[4]) begin errors++; $display("FAIL autoinc_data: got %0h expected %0h", edit_a, ref_a[4]); end
        m_adr = 4'd4; m_edit = ref_a[4]; m_dirty = 1'b0;
    endtask

    task automatic test_random_session();
        int ev;
        logic [3:0] k;
        logic fetch;
        for (int n = 0; n < 40; n++) begin
            ev = int'($urandom_range(0, 5));
            k = 4'($urandom);
            fetch = 1'b0;
            case (ev)
                0, 1: begin
                    key_valid = 1'b1; key_code = k;
                    m_edit = {m_edit[3:0], k}; m_dirty = 1'b1;
                end
                2: begin
                    next_p = 1'b1; key_valid = $urandom_range(0, 1) == 1; key_code = k;
                    m_adr = m_adr + 4'd1; fetch = 1'b1;
                end
                3: begin
                    prev_p = 1'b1;
                    m_adr = m_adr - 4'd1; fetch = 1'b1;
                end
                4: begin
                    goto_p = 1'b1; base_adr = k; next_p = $urandom_range(0, 1) == 1;
                    m_adr = k; fetch = 1'b1;
                end
                default: begin
                    write_p = 1'b1; key_valid = $urandom_range(0, 1) == 1; key_code = k;
                    ref_a[m_adr] = m_edit; m_adr = m_adr + 4'd1; fetch = 1'b1;
                end
            endcase
            tick(); clear_ev();
            if (fetch) begin
                wait_ready(0, "rand");
                m_edit = ref_a[m_adr]; m_dirty = 1'b0;
            end
            checks++; if (adr_a !== m_adr || edit_a !== m_edit || dirty_a !== m_dirty) begin
                errors++; $display("FAIL rand_%0d ev%0d: got adr=%0h data=%0h dirty=%0b expected %0h %0h %0b",
                                   n, ev, adr_a, edit_a, dirty_a, m_adr, m_edit, m_dirty); end
        end
    endtask

    task automatic test_prog_drop();
        key_valid = 1'b1; key_code = 4'hC; tick(); clear_ev();
        m_edit = {m_edit[3:0], 4'hC};
        write_p = 1'b1; tick(); clear_ev();
        prog_a = 1'b0; #1;
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL prog_gate_we: got %0b expected 0", we_a); end
        tick();
        checks++; if (busy_a !== 1'b0 || we_a !== 1'b0 || re_a !== 1'b0) begin
            errors++; $display("FAIL prog_drop_idle: got busy=%0b we=%0b re=%0b expected 0 0 0", busy_a, we_a, re_a); end
        checks++; if (adr_a !== m_adr || edit_a !== m_edit || dirty_a !== 1'b0) begin
            errors++; $display("FAIL prog_drop_keep: got adr=%0h data=%0h dirty=%0b expected %0h %0h 0", adr_a, edit_a, dirty_a, m_adr, m_edit); end
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++; if (mem_a[i] !== ref_a[i]) begin errors++; $display("FAIL mem_a[%0d]: got %0h expected %0h", i, mem_a[i], ref_a[i]); end
        end
    endtask

    task automatic test_wrap_noinc();
        logic [7:0] e;
        goto_p = 1'b1; base_adr = 4'd15; tick(); clear_ev();
        prog_b = 1'b1; tick();
        wait_ready(1, "b_entry");
        checks++; if (adr_b !== 4'd15 || edit_b !== ref_b[15]) begin errors++; $display("FAIL b_entry: got adr=%0h data=%0h expected f %0h", adr_b, edit_b, ref_b[15]); end
        next_p = 1'b1; tick(); clear_ev();
        checks++; if (adr_b !== 4'd0 || re_b !== 1'b1) begin errors++; $display("FAIL wrap_up: got adr=%0h re=%0b expected 0 1", adr_b, re_b); end
        wait_ready(1, "b_up");
        checks++; if (edit_b !== ref_b[0]) begin errors++; $display("FAIL wrap_up_data: got %0h expected %0h", edit_b, ref_b[0]); end
        prev_p = 1'b1; tick(); clear_ev();
        checks++; if (adr_b !== 4'd15 || re_b !== 1'b1) begin errors++; $display("FAIL wrap_down: got adr=%0h re=%0b expected f 1", adr_b, re_b); end
        wait_ready(1, "b_down");
        next_p = 1'b1; prev_p = 1'b1; tick(); clear_ev();
        checks++; if (adr_b !== 4'd15 || re_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL next_prev_cancel: got adr=%0h re=%0b busy=%0b expected f 0 0", adr_b, re_b, busy_b); end
        e = {ref_b[15][3:0], 4'h7};
        key_valid = 1'b1; key_code = 4'h7; tick(); clear_ev();
        write_p = 1'b1; key_valid = 1'b1; key_code = 4'h9; tick(); clear_ev();
        checks++; if (we_b !== 1'b1 || wdata_b !== e || adr_b !== 4'd15) begin
            errors++; $display("FAIL write_over_key: got we=%0b data=%0h adr=%0h expected 1 %0h f", we_b, wdata_b, adr_b, e); end
        tick();
        checks++; if (busy_b !== 1'b0 || re_b !== 1'b0 || adr_b !== 4'd15 || edit_b !== e || dirty_b !== 1'b0) begin
            errors++; $display("FAIL noinc_return: got busy=%0b re=%0b adr=%0h data=%0h dirty=%0b expected 0 0 f %0h 0",
                               busy_b, re_b, adr_b, edit_b, dirty_b, e); end
        checks++; if (mem_b[15] !== e) begin errors++; $display("FAIL noinc_mem: got %0h expected %0h", mem_b[15], e); end
        prog_b = 1'b0; tick();
    endtask

    task automatic test_wide_latency();
        int n;
        goto_p = 1'b1; base_adr = 4'd2; tick(); clear_ev();
        prog_c = 1'b1;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n = i;
            if (!busy_c) break;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL wide_latency: got %0d cycles expected 5", n); end
        checks++; if (edit_c !== 16'hBEEF) begin errors++; $display("FAIL wide_fetch: got %0h expected beef", edit_c); end
        for (int i = 1; i <= 5; i++) begin
            key_valid = 1'b1; key_code = 4'(i); tick(); clear_ev();
        end
        checks++; if (edit_c !== 16'h2345 || dirty_c !== 1'b1) begin errors++; $display("FAIL wide_keys: got %0h dirty=%0b expected 2345 1", edit_c, dirty_c); end
        next_p = 1'b1; tick(); clear_ev();
        tick();
        key_valid = 1'b1; key_code = 4'hA; tick(); clear_ev();
        wait_ready(2, "wide_next");
        checks++; if (adr_c !== 4'd3 || edit_c !== ref_c[3] || dirty_c !== 1'b0) begin
            errors++; $display("FAIL key_in_wait: got adr=%0h data=%0h dirty=%0b expected 3 %0h 0", adr_c, edit_c, dirty_c, ref_c[3]); end
        prog_c = 1'b0; tick();
    endtask

    task automatic test_clr_wait();
        prog_a = 1'b1; tick(); tick();
        checks++; if (busy_a !== 1'b1 || re_a !== 1'b0) begin errors++; $display("FAIL pre_clr_wait: got busy=%0b re=%0b expected 1 0", busy_a, re_a); end
        clr = 1'b1; prog_a = 1'b0; #1;
        checks++; if (adr_a !== 4'd0 || edit_a !== 8'd0 || dirty_a !== 1'b0 || busy_a !== 1'b0 || re_a !== 1'b0 || we_a !== 1'b0) begin
            errors++; $display("FAIL clr_async: got adr=%0h data=%0h dirty=%0b busy=%0b re=%0b we=%0b expected all 0",
                               adr_a, edit_a, dirty_a, busy_a, re_a, we_a); end
        tick(); clr = 1'b0; tick(); tick();
        checks++; if (we_a !== 1'b0 || busy_a !== 1'b0 || edit_a !== 8'd0) begin
            errors++; $display("FAIL clr_discard: got we=%0b busy=%0b data=%0h expected 0 0 0", we_a, busy_a, edit_a); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_edit_write();
        test_random_session();
        test_prog_drop();
        test_wrap_noinc();
        test_wide_latency();
        test_clr_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_loader.md
# fp_loader

Parametrised front-panel memory loader for the SAP-family boards. It turns debounced panel events into a read-modify-write session on program RAM:
- hex keypad nibbles
- next/prev/goto address
- write

Address and data widths are generic, and read-back latency is configurable. Optional auto-increment after each write. It sits between the debounce/keypad blocks and the memory's front-panel port, and replaces the ad-hoc address/pad-byte logic in board tops.

## Interface
Parameters:
- ADDR_W, 4, address width (≥1)
- DATA_W, 8, data width; multiple of 4, ≥4
- RD_LAT, 1, memory read latency in cycles (≥1)
- AUTO_INC, 1, 1 = advance address and re-fetch after each write

Ports:
- CLOCK_100MHZ  in  1  system clock
- CLR  in  1  reset, asynchronous, active-high
- prog  in  1  program mode enable (level, already debounced)
- key_valid  in  1  one-cycle pulse: keypad digit pressed
- key_code  in  4  hex value of digit, valid with key_valid
- next_p  in  1  one-cycle pulse: address +1
- prev_p  in  1  one-cycle pulse: address −1
- goto_p  in  1  one-cycle pulse: load base_adr
- base_adr  in  ADDR_W  target for goto_p
- write_p  in  1  one-cycle pulse: commit edit_data
- mem_rdata  in  DATA_W  memory read data
- mem_adr  out  ADDR_W  current address (registered)
- mem_re  out  1  read strobe, one cycle
- mem_we  out  1  write strobe, one cycle
- mem_wdata  out  DATA_W  equals edit_data
- edit_data  out  DATA_W  byte being edited (for display)
- dirty  out  1  edit_data differs from last fetch/commit
- busy  out  1  high in FETCH/WAIT/WRITE; events ignored

## Operation
States:
- IDLE, FETCH, WAIT, EDIT, WRITE
- Reset: state IDLE; mem_adr, edit_data = 0; dirty, mem_re, mem_we, busy = 0.

Transitions:
- IDLE: prog=1 → FETCH. All events are ignored, except goto_p: it loads base_adr into mem_adr with no fetch.
- FETCH: mem_re=1 for exactly one cycle → WAIT.
- WAIT: counts RD_LAT cycles. On the last one: edit_data ← mem_rdata, dirty ← 0 → EDIT.
- EDIT: accepts events, one per cycle, priority write_p > goto_p > next_p/prev_p > key_valid:
  - write_p → WRITE.
  - goto_p → mem_adr ← base_adr, FETCH.
  - next_p alone → mem_adr+1 (wraps 2^ADDR_W−1→0), FETCH.
  - prev_p alone → mem_adr−1 (wraps 0→2^ADDR_W−1), FETCH.
  - next_p and prev_p together → both ignored.
  - key_valid → edit_data ← {edit_data[DATA_W−5:0], key_code}, dirty ← 1.
  - Lower-priority events in the same cycle are dropped.
  - Address moves discard unsaved edits.
- WRITE: mem_we=1 for one cycle, with the current mem_adr/edit_data; dirty ← 0.
  - AUTO_INC=1: mem_adr+1 (wraps) → FETCH.
  - AUTO_INC=0: → EDIT; edit_data is retained.
- prog=0 in any state → IDLE next cycle. mem_we and mem_re are gated by prog combinationally, so no strobe is issued in a cycle where prog=0. mem_adr is retained; edit_data is retained; dirty ← 0.
- CLR mid-session: immediate return to reset values; any in-flight read is discarded.

## Timing
- prog rises at edge t → FETCH at t+1 (mem_re high); EDIT at t+RD_LAT+2.
- edit_data is valid in the first EDIT cycle.
- Key/address event sampled at edge t → edit_data/mem_adr updated at t+1.
- write_p sampled at t → mem_we high in cycle t+1.
  - AUTO_INC=1: next mem_re in cycle t+2.
- Events during busy are dropped, not queued. Panel events arrive at most every ~1 ms, so no loss in practice.
- All outputs are registered, except the prog gating on mem_we/mem_re.

## Structure
- Shared package sap_fp_pkg holds:
  - state enum (fp_state_t)
  - event-priority constants
  - parameter range checks (DATA_W%4==0, RD_LAT≥1)
- One sub-module is natural: fp_nibble_shift, a DATA_W-wide shift register with nibble insert and parallel load (from mem_rdata).
- Address arithmetic and the FSM stay in fp_loader.

## Test plan
- Defaults, memory preloaded with mem[3]=8'hA5; goto_p with base_adr=3 in IDLE, then prog=1 → mem_re in the cycle after prog is sampled; edit_data=8'hA5 in the first EDIT cycle; dirty=0.
- In EDIT with edit_data=8'hA5, keys 1 then 2 → edit_data=8'h12, dirty=1; then write_p → one-cycle mem_we at adr 3, data 8'h12; adr becomes 4; re-fetch issued.
- AUTO_INC=0, ADDR_W=4, adr=15: next_p → adr 0 with fetch; prev_p → adr 15. next_p and prev_p in the same cycle → adr unchanged, no mem_re.
- DATA_W=16, RD_LAT=3: fetch → EDIT exactly 5 cycles after prog is sampled; keys 1,2,3,4,5 → edit_data=16'h2345.
- write_p and key_valid in the same cycle → write of the old edit_data; key dropped. Key pulse during WAIT → ignored.
- prog dropped in the WRITE cycle → mem_we stays 0, IDLE next cycle. CLR asserted during WAIT → all outputs at reset values immediately; no write issued.
